imm_decode_ctrl: RTL and testbench
==================================

IMM_DECODE_CTRL -- requirements
Module: imm_decode_ctrl

Interface
REQ-001 Parameter: CNT_W, 8, width of the saturating illegal-instruction counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  upstream instruction beat valid.
REQ-005 in_ready  output  1  block can accept a beat this cycle.
REQ-006 in_instr  input  32  instruction word.
REQ-007 in_pc  input  32  PC of the instruction.
REQ-008 flush  input  1  discard all buffered and incoming beats.
REQ-009 out_valid  output  1  decoded beat at head is valid.
REQ-010 out_ready  input  1  downstream accepts the head beat.
REQ-011 out_instr  output  32  head instruction, for the immediate generator.
REQ-012 out_pc  output  32  head PC.
REQ-013 imm_sel  output  4  immediate-generator select: 0 I, 1 S, 2 B, 3 J, 4 U, 15 none/illegal.
REQ-014 out_illegal  output  1  head instruction is illegal.
REQ-015 illegal_count  output  CNT_W  saturating count of accepted illegal instructions.

Function
REQ-016 The block SHALL be a 2-entry in-order buffer with states EMPTY, ONE, TWO, encoded as an occupancy count.
REQ-017 in_ready SHALL be 1 in EMPTY and ONE, and 0 in TWO; it SHALL NOT depend combinationally on out_ready.
REQ-018 Push SHALL occur when in_valid && in_ready && !flush; pop SHALL occur when out_valid && out_ready && !flush.
REQ-019 Transitions: EMPTY->ONE on push; ONE->TWO on push without pop; ONE->EMPTY on pop without push; ONE stays ONE on simultaneous push and pop; TWO->ONE on pop.
REQ-020 out_valid SHALL equal (state != EMPTY); all head outputs SHALL come from the oldest entry; accept-to-out_valid latency SHALL be 1 cycle.
REQ-021 Decode SHALL be performed at push time and stored per entry; imm_sel and out_illegal SHALL be registered, never combinational from in_instr.
REQ-022 Decode from instr[6:0]: 0000011, 0010011, 1100111, 0001111, 1110011 -> 0; 0100011 -> 1; 1100011 -> 2; 1101111 -> 3; 0110111, 0010111 -> 4; 0110011 -> 15 with illegal=0.
REQ-023 Any other opcode, including any with instr[1:0] != 2'b11, SHALL decode to imm_sel=15, illegal=1.
REQ-024 illegal_count SHALL increment by 1 on each push whose decoded illegal=1 and SHALL hold at 2^CNT_W-1 (no wrap).
REQ-025 flush SHALL force next state EMPTY, drop any beat presented that cycle, and leave illegal_count unchanged for the dropped beat.
REQ-026 While out_valid=1 and out_ready=0, out_instr, out_pc, imm_sel and out_illegal SHALL remain stable.
REQ-027 Non-head outputs (out_instr, out_pc, imm_sel, out_illegal) SHALL read 0 / 15 / 0 when EMPTY: out_instr=0, out_pc=0, imm_sel=15, out_illegal=0.

Reset
REQ-028 reset=1 at a clock edge SHALL set state EMPTY, out_valid=0, in_ready=1, illegal_count=0, head outputs per REQ-027, overriding push, pop and flush in that cycle.
REQ-029 Reset asserted mid-operation SHALL discard all buffered entries; first push after reset release SHALL appear with 1-cycle latency.

Verification
REQ-030 Reset: hold reset 2 cycles with in_valid=1 -> out_valid=0, in_ready=1, illegal_count=0, imm_sel=15.
REQ-031 Single beat: push 0x00500093, pc 0x100, out_ready=1 -> next cycle out_valid=1, imm_sel=0, out_pc=0x100, out_illegal=0; following cycle out_valid=0.
REQ-032 Backpressure: out_ready=0, offer 0x00112023, 0x00208463, 0x0080006F -> first two accepted, in_ready=0, third held; raise out_ready -> heads in order with imm_sel 1, 2, 3.
REQ-033 Illegal/saturation: push 0xFFFFFFFE -> imm_sel=15, out_illegal=1, illegal_count=1; push 300 such beats -> illegal_count=255.
REQ-034 Flush: state TWO with in_valid=1 (illegal word) and flush=1 -> next cycle out_valid=0, in_ready=1, illegal_count unchanged.
REQ-035 Simultaneous push/pop in ONE with out_ready=1 for 10 cycles of 0x12345037 -> out_valid stays 1, imm_sel=4 every cycle, no beat lost or duplicated.

Source files
------------

// File: rtl/imm_decode_ctrl.sv
// imm_decode_ctrl: two-entry in-order skid buffer that pre-decodes the
// immediate format of each accepted instruction and counts illegal ones.
module imm_decode_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [31:0]      out_pc,
    output logic [3:0]       imm_sel,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [3:0]  sel;
        logic        ill;
    } entry_t;

    localparam logic [3:0] SEL_I    = 4'd0;
    localparam logic [3:0] SEL_S    = 4'd1;
    localparam logic [3:0] SEL_B    = 4'd2;
    localparam logic [3:0] SEL_J    = 4'd3;
    localparam logic [3:0] SEL_U    = 4'd4;
    localparam logic [3:0] SEL_NONE = 4'd15;

    localparam entry_t BLANK = '{
        instr: 32'd0,
        pc:    32'd0,
        sel:   SEL_NONE,
        ill:   1'b0
    };

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    entry_t           head;
    entry_t           tail;
    entry_t           dec;
    logic [CNT_W-1:0] cnt;
    logic             push;
    logic             pop;

    // Decode the incoming word so each entry stores its format at push time
    always_comb begin
        dec       = BLANK;
        dec.instr = in_instr;
        dec.pc    = in_pc;
        dec.sel   = SEL_NONE;
        dec.ill   = 1'b0;
        case (in_instr[6:0])
            7'b0000011,
            7'b0010011,
            7'b1100111,
            7'b0001111,
            7'b1110011: dec.sel = SEL_I;
            7'b0100011: dec.sel = SEL_S;
            7'b1100011: dec.sel = SEL_B;
            7'b1101111: dec.sel = SEL_J;
            7'b0110111,
            7'b0010111: dec.sel = SEL_U;
            7'b0110011: dec.sel = SEL_NONE;
            default:    dec.ill = 1'b1;
        endcase
    end

    // Handshake terms; ready/valid come only from the occupancy register
    always_comb begin
        in_ready  = (state != TWO);
        out_valid = (state != EMPTY);
        push      = in_valid && in_ready && !flush;
        pop       = out_valid && out_ready && !flush;
    end

    // Occupancy, entry storage and the saturating illegal counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
            head  <= BLANK;
            tail  <= BLANK;
            cnt   <= '0;
        end else begin
            if (push && dec.ill && (cnt != CNT_MAX)) begin
                cnt <= cnt + CNT_ONE;
            end
            if (flush) begin
                state <= EMPTY;
                head  <= BLANK;
                tail  <= BLANK;
            end else begin
                unique case (state)
                    EMPTY: begin
                        if (push) begin
                            head  <= dec;
                            state <= ONE;
                        end
                    end
                    ONE: begin
                        if (push && pop) begin
                            head <= dec;
                        end else if (push) begin
                            tail  <= dec;
                            state <= TWO;
                        end else if (pop) begin
                            head  <= BLANK;
                            state <= EMPTY;
                        end
                    end
                    TWO: begin
                        if (pop) begin
                            head  <= tail;
                            tail  <= BLANK;
                            state <= ONE;
                        end
                    end
                    default: begin
                        state <= EMPTY;
                        head  <= BLANK;
                        tail  <= BLANK;
                    end
                endcase
            end
        end
    end

    // Head outputs are straight from the oldest entry register
    always_comb begin
        out_instr     = head.instr;
        out_pc        = head.pc;
        imm_sel       = head.sel;
        out_illegal   = head.ill;
        illegal_count = cnt;
    end

endmodule

// File: tb/tb_imm_decode_ctrl.sv
// tb_imm_decode_ctrl: directed scenario tests for imm_decode_ctrl.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_imm_decode_ctrl;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [3:0]  imm_sel;
    logic        out_illegal;
    logic [7:0]  illegal_count;

    int tests;
    int fails;

    imm_decode_ctrl #(.CNT_W(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .imm_sel       (imm_sel),
        .out_illegal   (out_illegal),
        .illegal_count (illegal_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'hFFFF_FFFE;
        in_pc     = 32'h40;
        out_ready = 1'b0;
        flush     = 1'b0;
        step();
        step();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        tests++;
        if (illegal_count !== 8'd0) begin
            fails++;
            $display("FAIL reset_count got %0d want 0", illegal_count);
        end
        tests++;
        if (imm_sel !== 4'd15 || out_instr !== 32'd0 || out_pc !== 32'd0
            || out_illegal !== 1'b0) begin
            fails++;
            $display("FAIL reset_head got sel=%0d instr=%h pc=%h ill=%b want 15/0/0/0",
                     imm_sel, out_instr, out_pc, out_illegal);
        end
        reset    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h0050_0093;
        in_pc     = 32'h100;
        step();
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || imm_sel !== 4'd0 || out_pc !== 32'h100
            || out_illegal !== 1'b0 || out_instr !== 32'h0050_0093) begin
            fails++;
            $display("FAIL single_head got v=%b sel=%0d pc=%h ill=%b instr=%h want 1/0/100/0/00500093",
                     out_valid, imm_sel, out_pc, out_illegal, out_instr);
        end
        step();
        tests++;
        if (out_valid !== 1'b0 || imm_sel !== 4'd15) begin
            fails++;
            $display("FAIL single_drain got v=%b sel=%0d want 0/15", out_valid, imm_sel);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h0011_2023;
        in_pc     = 32'h200;
        step();
        tests++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || imm_sel !== 4'd1) begin
            fails++;
            $display("FAIL bp_one got v=%b rdy=%b sel=%0d want 1/1/1",
                     out_valid, in_ready, imm_sel);
        end
        in_instr = 32'h0020_8463;
        in_pc    = 32'h204;
        step();
        tests++;
        if (in_ready !== 1'b0 || out_pc !== 32'h200 || imm_sel !== 4'd1) begin
            fails++;
            $display("FAIL bp_two got rdy=%b pc=%h sel=%0d want 0/200/1",
                     in_ready, out_pc, imm_sel);
        end
        in_instr = 32'h0080_006F;
        in_pc    = 32'h208;
        step();
        step();
        tests++;
        if (in_ready !== 1'b0 || out_pc !== 32'h200 || imm_sel !== 4'd1
            || out_instr !== 32'h0011_2023 || out_illegal !== 1'b0) begin
            fails++;
            $display("FAIL bp_hold got rdy=%b pc=%h sel=%0d instr=%h want 0/200/1/00112023",
                     in_ready, out_pc, imm_sel, out_instr);
        end
        out_ready = 1'b1;
        step();
        tests++;
        if (out_valid !== 1'b1 || out_pc !== 32'h204 || imm_sel !== 4'd2
            || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_head2 got v=%b pc=%h sel=%0d rdy=%b want 1/204/2/1",
                     out_valid, out_pc, imm_sel, in_ready);
        end
        step();
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || out_pc !== 32'h208 || imm_sel !== 4'd3) begin
            fails++;
            $display("FAIL bp_head3 got v=%b pc=%h sel=%0d want 1/208/3",
                     out_valid, out_pc, imm_sel);
        end
        step();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_drain got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_decode();
        logic [31:0] words [9];
        logic [3:0]  sels  [9];
        logic        ills  [9];
        words = '{32'h0000_0003, 32'h0000_0067, 32'h0000_000F,
                  32'h0000_0073, 32'h0000_0017, 32'h0000_0033,
                  32'h0000_007F, 32'h0000_0001, 32'h0000_005B};
        sels  = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd4, 4'd15, 4'd15, 4'd15, 4'd15};
        ills  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_instr = words[i];
            in_pc    = 32'h300 + 32'(i * 4);
            step();
            tests++;
            if (out_valid !== 1'b1 || imm_sel !== sels[i]
                || out_illegal !== ills[i] || out_instr !== words[i]) begin
                fails++;
                $display("FAIL decode_%0d got v=%b sel=%0d ill=%b instr=%h want 1/%0d/%b/%h",
                         i, out_valid, imm_sel, out_illegal, out_instr,
                         sels[i], ills[i], words[i]);
            end
        end
        in_valid = 1'b0;
        step();
        tests++;
        if (illegal_count !== 8'd3) begin
            fails++;
            $display("FAIL decode_count got %0d want 3", illegal_count);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h0050_0093;
        in_pc     = 32'h400;
        step();
        in_instr = 32'hFFFF_FFFE;
        flush    = 1'b1;
        step();
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || illegal_count !== 8'd3) begin
            fails++;
            $display("FAIL flush_one got v=%b rdy=%b cnt=%0d want 0/1/3",
                     out_valid, in_ready, illegal_count);
        end
        flush    = 1'b0;
        in_instr = 32'h0050_0093;
        step();
        in_instr = 32'h0011_2023;
        step();
        tests++;
        if (in_ready !== 1'b0 || out_pc !== 32'h400) begin
            fails++;
            $display("FAIL flush_fill got rdy=%b pc=%h want 0/400", in_ready, out_pc);
        end
        in_instr = 32'hFFFF_FFFE;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || illegal_count !== 8'd3
            || imm_sel !== 4'd15) begin
            fails++;
            $display("FAIL flush_two got v=%b rdy=%b cnt=%0d sel=%0d want 0/1/3/15",
                     out_valid, in_ready, illegal_count, imm_sel);
        end
        step();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush_after got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h0011_2023;
        in_pc     = 32'h500;
        step();
        step();
        reset = 1'b1;
        step();
        reset    = 1'b0;
        in_instr = 32'h0020_8463;
        in_pc    = 32'h600;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || illegal_count !== 8'd0) begin
            fails++;
            $display("FAIL midreset_state got v=%b rdy=%b cnt=%0d want 0/1/0",
                     out_valid, in_ready, illegal_count);
        end
        step();
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || out_pc !== 32'h600 || imm_sel !== 4'd2) begin
            fails++;
            $display("FAIL midreset_push got v=%b pc=%h sel=%0d want 1/600/2",
                     out_valid, out_pc, imm_sel);
        end
        out_ready = 1'b1;
        step();
    endtask

    task automatic test_illegal_sat();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'hFFFF_FFFE;
        in_pc     = 32'h700;
        step();
        tests++;
        if (imm_sel !== 4'd15 || out_illegal !== 1'b1 || illegal_count !== 8'd1) begin
            fails++;
            $display("FAIL illegal_first got sel=%0d ill=%b cnt=%0d want 15/1/1",
                     imm_sel, out_illegal, illegal_count);
        end
        for (int i = 0; i < 253; i++) step();
        tests++;
        if (illegal_count !== 8'd254) begin
            fails++;
            $display("FAIL illegal_254 got %0d want 254", illegal_count);
        end
        step();
        tests++;
        if (illegal_count !== 8'd255) begin
            fails++;
            $display("FAIL illegal_255 got %0d want 255", illegal_count);
        end
        for (int i = 0; i < 45; i++) step();
        in_valid = 1'b0;
        tests++;
        if (illegal_count !== 8'd255 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL illegal_sat got cnt=%0d v=%b want 255/1",
                     illegal_count, out_valid);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] pc;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h1234_5037;
        for (int i = 0; i < 10; i++) begin
            pc    = 32'h800 + 32'(i * 4);
            in_pc = pc;
            step();
            tests++;
            if (out_valid !== 1'b1 || imm_sel !== 4'd4 || out_pc !== pc
                || in_ready !== 1'b1) begin
                fails++;
                $display("FAIL b2b_%0d got v=%b sel=%0d pc=%h rdy=%b want 1/4/%h/1",
                         i, out_valid, imm_sel, out_pc, in_ready, pc);
            end
        end
        in_valid = 1'b0;
        step();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_drain got v=%b want 0", out_valid);
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_instr  = 32'd0;
        in_pc     = 32'd0;
        flush     = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_decode();
        test_flush();
        test_reset_mid();
        test_illegal_sat();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
